// File: rtl/nx_fifo_pf_pkg.sv
// Shared constants and helpers for the FIFO read-side prefetcher.
package nx_fifo_pf_pkg;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 3;
    localparam int unsigned PERF_CNT_W = 16;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int unsigned pf_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/nx_fifo_rd_prefetch_if.sv
// FIFO-controller read port plus valid/ready output stream of the prefetcher.
interface nx_fifo_rd_prefetch_if #(
    parameter int unsigned DATA_W = 32
);
    logic              fifo_empty;
    logic              fifo_ren;
    logic [DATA_W-1:0] fifo_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        input  fifo_empty, fifo_rdata, out_ready,
        output fifo_ren, out_valid, out_data
    );

    modport slave (
        output fifo_empty, fifo_rdata, out_ready,
        input  fifo_ren, out_valid, out_data
    );
endinterface

// File: rtl/nx_fifo_pf_buf.sv
// Circular register FIFO with flush, arbitrary (non power of two) depth and
// a head output taken straight from registers.
module nx_fifo_pf_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pop_ok;

    // Wrap explicitly at DEPTH-1 since DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        pop_ok   = pop && (cnt_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_valid = (cnt_q != '0);
    assign head_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/nx_fifo_rd_prefetch.sv
// Read-side prefetcher: issues credit-limited reads and streams returned words.
// Optional perf counters (stall_cnt/starve_cnt) under NX_FIFO_RD_PREFETCH_PERF_EN.
module nx_fifo_rd_prefetch
    import nx_fifo_pf_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned PF_DEPTH   = RD_LATENCY + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    nx_fifo_rd_prefetch_if.master             bus,
    output logic [pf_cnt_w(PF_DEPTH)-1:0]     pf_used
`ifdef NX_FIFO_RD_PREFETCH_PERF_EN
  , output logic [PERF_CNT_W-1:0]             stall_cnt
  , output logic [PERF_CNT_W-1:0]             starve_cnt
`endif
);

    localparam int unsigned CNT_W = pf_cnt_w(PF_DEPTH);

    logic [CNT_W-1:0]      used_q, used_d;
    logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [CNT_W-1:0]      used_after_pop;
    logic                  pop_c;
    logic                  ren_c;
    logic                  push_c;

    assign pop_c  = bus.out_valid && bus.out_ready;
    assign push_c = vld_pipe_q[RD_LATENCY-1] && !clear;

    // Credit check: in-flight plus buffered words, net of this cycle's pop.
    always_comb begin
        used_after_pop = used_q - CNT_W'(pop_c);
        ren_c          = !bus.fifo_empty && !clear && !rst &&
                         (used_after_pop < CNT_W'(PF_DEPTH));
    end

    always_comb begin
        used_d     = used_q;
        vld_pipe_d = vld_pipe_q;
        if (clear) begin
            used_d     = '0;
            vld_pipe_d = '0;
        end else begin
            used_d     = used_q + CNT_W'(ren_c) - CNT_W'(pop_c);
            vld_pipe_d = (vld_pipe_q << 1) | RD_LATENCY'(ren_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            used_q     <= '0;
            vld_pipe_q <= '0;
        end else begin
            used_q     <= used_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign bus.fifo_ren = ren_c;
    assign pf_used      = used_q;

    nx_fifo_pf_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (PF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (clear),
        .push       (push_c),
        .push_data  (bus.fifo_rdata),
        .pop        (pop_c),
        .head_valid (bus.out_valid),
        .head_data  (bus.out_data)
    );

`ifdef NX_FIFO_RD_PREFETCH_PERF_EN
    logic [PERF_CNT_W-1:0] stall_q, stall_d;
    logic [PERF_CNT_W-1:0] starve_q, starve_d;

    // Saturating counters of consumer back-pressure and producer starvation.
    always_comb begin
        stall_d  = stall_q;
        starve_d = starve_q;
        if (clear) begin
            stall_d  = '0;
            starve_d = '0;
        end else begin
            if (bus.out_valid && !bus.out_ready && (stall_q != '1)) begin
                stall_d = stall_q + PERF_CNT_W'(1);
            end
            if (!bus.out_valid && bus.out_ready && (starve_q != '1)) begin
                starve_d = starve_q + PERF_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            starve_q <= '0;
        end else begin
            stall_q  <= stall_d;
            starve_q <= starve_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign starve_cnt = starve_q;
`endif

endmodule
